// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-ported memory between the IF and D ports.
// D has priority; a saturating starvation counter forces an IF grant after STARVE_LIMIT D grants.
module mem_port_arbiter #(
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned STARVE_LIMIT  = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      if_req,
  input  logic [ADDRESS_WIDTH-1:0]  if_addr,
  output logic                      if_done,
  output logic [DATA_WIDTH-1:0]     if_rdata,
  input  logic                      d_req,
  input  logic                      d_we,
  input  logic [ADDRESS_WIDTH-1:0]  d_addr,
  input  logic [DATA_WIDTH-1:0]     d_wdata,
  input  logic [DATA_WIDTH/8-1:0]   d_wstrb,
  output logic                      d_done,
  output logic [DATA_WIDTH-1:0]     d_rdata,
  output logic                      mem_req,
  output logic                      mem_we,
  output logic [ADDRESS_WIDTH-1:0]  mem_addr,
  output logic [DATA_WIDTH-1:0]     mem_wdata,
  output logic [DATA_WIDTH/8-1:0]   mem_wstrb,
  input  logic                      mem_ready,
  input  logic [DATA_WIDTH-1:0]     mem_rdata,
  output logic                      busy
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned CNT_WIDTH  = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D, RESP} state_t;

  state_t                    state, state_n;
  logic [CNT_WIDTH-1:0]      starve_cnt, starve_cnt_n;
  logic                      if_done_n, d_done_n, mem_req_n, mem_we_n, busy_n;
  logic [DATA_WIDTH-1:0]     if_rdata_n, d_rdata_n, mem_wdata_n;
  logic [ADDRESS_WIDTH-1:0]  mem_addr_n;
  logic [STRB_WIDTH-1:0]     mem_wstrb_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      starve_cnt <= '0;
      if_done    <= 1'b0;
      if_rdata   <= '0;
      d_done     <= 1'b0;
      d_rdata    <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_wstrb  <= '0;
      busy       <= 1'b0;
    end else begin
      state      <= state_n;
      starve_cnt <= starve_cnt_n;
      if_done    <= if_done_n;
      if_rdata   <= if_rdata_n;
      d_done     <= d_done_n;
      d_rdata    <= d_rdata_n;
      mem_req    <= mem_req_n;
      mem_we     <= mem_we_n;
      mem_addr   <= mem_addr_n;
      mem_wdata  <= mem_wdata_n;
      mem_wstrb  <= mem_wstrb_n;
      busy       <= busy_n;
    end
  end

  // Every output is computed as a next-value here so it lands registered with the state change.
  always_comb begin
    state_n      = state;
    starve_cnt_n = starve_cnt;
    if_done_n    = 1'b0;
    d_done_n     = 1'b0;
    if_rdata_n   = if_rdata;
    d_rdata_n    = d_rdata;
    mem_req_n    = mem_req;
    mem_we_n     = mem_we;
    mem_addr_n   = mem_addr;
    mem_wdata_n  = mem_wdata;
    mem_wstrb_n  = mem_wstrb;

    case (state)
      IDLE: begin
        if (d_req && !(if_req && starve_cnt == CNT_MAX)) begin
          state_n      = GRANT_D;
          mem_req_n    = 1'b1;
          mem_we_n     = d_we;
          mem_addr_n   = d_addr;
          mem_wdata_n  = d_wdata;
          mem_wstrb_n  = d_we ? d_wstrb : '0;
          if (!if_req)
            starve_cnt_n = '0;
          else if (starve_cnt != CNT_MAX)
            starve_cnt_n = starve_cnt + CNT_WIDTH'(1);
        end else if (if_req) begin
          state_n      = GRANT_I;
          mem_req_n    = 1'b1;
          mem_we_n     = 1'b0;
          mem_addr_n   = if_addr;
          mem_wdata_n  = '0;
          mem_wstrb_n  = '0;
          starve_cnt_n = '0;
        end
      end
      GRANT_I: begin
        if (mem_ready) begin
          state_n    = RESP;
          mem_req_n  = 1'b0;
          if_done_n  = 1'b1;
          if_rdata_n = mem_rdata;
        end
      end
      GRANT_D: begin
        if (mem_ready) begin
          state_n   = RESP;
          mem_req_n = 1'b0;
          d_done_n  = 1'b1;
          if (!mem_we)
            d_rdata_n = mem_rdata;
        end
      end
      RESP: begin
        state_n = IDLE;
      end
    endcase

    busy_n = (state_n != IDLE);
  end

endmodule
